// File: rtl/config_stream_loader.sv
// rtl/config_stream_loader.sv - frames a byte stream into records for the tile configuration bus
module config_stream_loader #(
  parameter logic [31:0] IDLE_ADDR    = 32'h0000_0000,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] records_written
);

  // Index of the final cycle a record stays on the bus.
  localparam logic [3:0] WC_LAST = 4'(WRITE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        rst_sync_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] count_q;
  logic [15:0] records_written_q;
  logic [2:0]  idx_q;
  logic [3:0]  wcnt_q;
  // Only the first seven bytes need holding; the eighth is taken straight from in_data.
  logic [55:0] asm_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        xfer;
  logic [63:0] asm_d;
  logic [15:0] records_written_d;
  logic [15:0] count_d;

  assign xfer              = in_valid && in_ready_q;
  assign asm_d             = {asm_q, in_data};
  assign records_written_d = records_written_q + 16'd1;
  assign count_d           = {count_q[15:8], in_data};

  // Reset asserts immediately and releases on the next clk edge, so the FSM acts on the second edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  // Session FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q           <= S_IDLE;
      in_ready_q        <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      count_q           <= '0;
      records_written_q <= '0;
      idx_q             <= '0;
      wcnt_q            <= '0;
      asm_q             <= '0;
      addr_q            <= IDLE_ADDR;
      data_q            <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q           <= S_CNT_HI;
            busy_q            <= 1'b1;
            in_ready_q        <= 1'b1;
            records_written_q <= '0;
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            count_q[15:8] <= in_data;
            state_q       <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            count_q[7:0] <= in_data;
            idx_q        <= '0;
            if (count_d == 16'd0) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            asm_q <= asm_d[55:0];
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              addr_q     <= asm_d[63:32];
              data_q     <= asm_d[31:0];
              wcnt_q     <= '0;
            end
          end
        end
        S_WRITE: begin
          if (wcnt_q == WC_LAST) begin
            records_written_q <= records_written_d;
            addr_q            <= IDLE_ADDR;
            data_q            <= '0;
            if (records_written_d == count_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
              idx_q      <= '0;
            end
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          addr_q     <= IDLE_ADDR;
          data_q     <= '0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign records_written = records_written_q;
  assign config_addr     = addr_q;
  assign config_data     = data_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// tb/tb_config_stream_loader.sv - randomized directed bench with a time-window bus model
module tb_config_stream_loader;

  localparam time P = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  int         sel = 0;

  logic        start_a, start_b, valid_a, valid_b;
  logic        in_ready_a, in_ready_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] addr_a, addr_b, data_a, data_b;
  logic [15:0] rw_a, rw_b;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign valid_a = in_valid && (sel == 0);
  assign valid_b = in_valid && (sel == 1);

  config_stream_loader #(.IDLE_ADDR(32'h0000_0000), .WRITE_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(valid_a),
    .in_ready(in_ready_a), .config_addr(addr_a), .config_data(data_a),
    .busy(busy_a), .done(done_a), .records_written(rw_a));

  config_stream_loader #(.IDLE_ADDR(32'h0000_0000), .WRITE_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(valid_b),
    .in_ready(in_ready_b), .config_addr(addr_b), .config_data(data_b),
    .busy(busy_b), .done(done_b), .records_written(rw_b));

  int checks = 0;
  int errors = 0;

  // Reference model: each record is expected on the bus strictly inside (accept edge, accept edge + W*P).
  bit          mon_en = 1'b0;
  bit          m_active = 1'b0;
  time         t_start = 0;
  time         t_done = 0;
  time         w_lo[$];
  time         w_hi[$];
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  logic [31:0] rec_a[8];
  logic [31:0] rec_d[8];

  logic [31:0] e_addr, e_data;
  bit          e_inw, e_done, e_busy;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endfunction

  function automatic void clear_model();
    m_active = 1'b0;
    t_done   = 0;
    w_lo.delete(); w_hi.delete(); w_addr.delete(); w_data.delete();
  endfunction

  // Per-cycle comparison of the selected instance against the window model.
  always @(negedge clk) begin
    if (mon_en) begin
      e_addr = 32'h0; e_data = 32'h0; e_inw = 1'b0;
      foreach (w_lo[i]) begin
        if ($time > w_lo[i] && $time < w_hi[i]) begin
          e_addr = w_addr[i]; e_data = w_data[i]; e_inw = 1'b1;
        end
      end
      e_done = (t_done != 0) && ($time > t_done) && ($time < t_done + P);
      e_busy = m_active && ($time > t_start) && !((t_done != 0) && ($time > t_done));
      if (sel == 0) begin
        chk("bus_addr_a", addr_a, e_addr);
        chk("bus_data_a", data_a, e_data);
        chk("done_a", {31'h0, done_a}, {31'h0, e_done});
        chk("busy_a", {31'h0, busy_a}, {31'h0, e_busy});
        chk("in_ready_a", {31'h0, in_ready_a}, {31'h0, e_busy && !e_inw});
        chk("idle_other_b", {addr_b[31:1], busy_b}, 32'h0);
      end else begin
        chk("bus_addr_b", addr_b, e_addr);
        chk("bus_data_b", data_b, e_data);
        chk("done_b", {31'h0, done_b}, {31'h0, e_done});
        chk("busy_b", {31'h0, busy_b}, {31'h0, e_busy});
        chk("in_ready_b", {31'h0, in_ready_b}, {31'h0, e_busy && !e_inw});
        chk("idle_other_a", {addr_a[31:1], busy_a}, 32'h0);
      end
    end
  end

  task automatic begin_session();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    clear_model();
    t_start  = $time;
    m_active = 1'b1;
    #1 start = 1'b0;
  endtask

  // Offers one byte until the handshake completes; tacc is the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int duty, input bit stray, output time tacc);
    bit acc;
    int n;
    acc = 1'b0; n = 0; tacc = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      in_data  = b;
      in_valid = ($urandom_range(99) < duty);
      start    = stray && (n == 0);
      acc      = in_valid && ((sel == 0) ? in_ready_a : in_ready_b);
      @(posedge clk);
      tacc = $time;
      #1 start = 1'b0;
      n++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL handshake_timeout observed=%0d expected=1 byte=%h", acc, b);
    end
  endtask

  task automatic run_session(input int n, input int duty, input bit stray, input bit done_start);
    time         t;
    int          w;
    logic [15:0] nn;
    logic [63:0] rec;
    w  = (sel == 0) ? 1 : 3;
    nn = 16'(n);
    begin_session();
    send_byte(nn[15:8], duty, 1'b0, t);
    send_byte(nn[7:0], duty, 1'b0, t);
    if (n == 0) t_done = t;
    for (int r = 0; r < n; r++) begin
      rec = {rec_a[r], rec_d[r]};
      for (int k = 0; k < 8; k++) begin
        send_byte(rec[63 - 8*k -: 8], duty, stray && (r == 0) && (k == 2), t);
      end
      w_lo.push_back(t);
      w_hi.push_back(t + w * P);
      w_addr.push_back(rec_a[r]);
      w_data.push_back(rec_d[r]);
      if (r == n - 1) t_done = t + w * P;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = done_start;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (w + 3) @(negedge clk);
    chk("records_written", {16'h0, (sel == 0) ? rw_a : rw_b}, 32'(n));
    chk("busy_after", {31'h0, (sel == 0) ? busy_a : busy_b}, 32'h0);
  endtask

  initial begin
    time t;
    int  nrec;
    #2 reset = 1'b0;
    #1 mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr_a", addr_a, 32'h0);
    chk("rst_data_a", data_a, 32'h0);
    chk("rst_ready_a", {31'h0, in_ready_a}, 32'h0);
    chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
    chk("rst_done_a", {31'h0, done_a}, 32'h0);
    chk("rst_rw_a", {16'h0, rw_a}, 32'h0);
    chk("rst_addr_b", addr_b, 32'h0);
    chk("rst_rw_b", {16'h0, rw_b}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    // Single record, one-cycle write.
    sel = 0;
    rec_a[0] = 32'h0007_0003; rec_d[0] = 32'h0000_0005;
    run_session(1, 100, 1'b0, 1'b0);

    // Three records with in_valid held high.
    rec_a[0] = 32'h0006_0002; rec_d[0] = 32'h0000_0006;
    rec_a[1] = 32'h0005_0002; rec_d[1] = 32'h0000_0001;
    rec_a[2] = 32'h0004_0002; rec_d[2] = 32'h0000_0002;
    run_session(3, 100, 1'b0, 1'b0);

    // Empty session; a start pulse in the done cycle must be ignored.
    run_session(0, 100, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("start_in_done_ignored", {31'h0, busy_a}, 32'h0);

    // Two records with ~50% valid gaps and a start pulse while busy.
    run_session(2, 50, 1'b1, 1'b0);

    // Three-cycle write instance.
    sel = 1;
    m_active = 1'b0;
    rec_a[0] = 32'h0007_0003; rec_d[0] = 32'h0000_0005;
    run_session(1, 100, 1'b0, 1'b0);

    // Reset in the middle of record 1, then a clean session.
    sel = 0;
    m_active = 1'b0;
    rec_a[0] = 32'h0007_0003; rec_d[0] = 32'h0000_0005;
    begin_session();
    send_byte(8'h00, 100, 1'b0, t);
    send_byte(8'h01, 100, 1'b0, t);
    send_byte(8'h00, 100, 1'b0, t);
    send_byte(8'h07, 100, 1'b0, t);
    send_byte(8'h00, 100, 1'b0, t);
    send_byte(8'h03, 100, 1'b0, t);
    send_byte(8'h00, 100, 1'b0, t);
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    chk("abort_rw", {16'h0, rw_a}, 32'h0);
    chk("abort_busy", {31'h0, busy_a}, 32'h0);
    chk("abort_ready", {31'h0, in_ready_a}, 32'h0);
    chk("abort_addr", addr_a, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    run_session(1, 100, 1'b0, 1'b0);

    // Random sessions on both instances, including an address with a zero upper half.
    for (int s = 0; s < 8; s++) begin
      sel = int'($urandom_range(1));
      m_active = 1'b0;
      nrec = int'($urandom_range(4, 1));
      for (int r = 0; r < nrec; r++) begin
        rec_a[r] = $urandom;
        rec_d[r] = $urandom;
      end
      if (s == 0) rec_a[0] = 32'h0000_0009;
      run_session(nrec, ($urandom_range(1) == 1) ? 100 : 60, s[0], 1'b0);
    end

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Upstream stage of the PE tile array: converts a byte-wide configuration stream into the tile configuration bus (config_addr/config_data).
- The bus is broadcast to every tile. Each tile decodes config_addr[15:0] as tile_id and config_addr[31:16] as sub-block id: sb=7, cb0=6, cb1=5, compute_block=4.
- The block frames records, presents each record for a fixed number of cycles, and parks the bus on a non-matching idle address at all other times.

Parameters:
- IDLE_ADDR, 32'h0000_0000: bus address while no write is in progress. Sub-block id 0 is reserved and matches no tile.
- WRITE_CYCLES, 1: cycles each record is held on the bus. Legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle pulse; begins a load session
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- config_addr  output  32  {sub-block id, tile_id} to tiles
- config_data  output  32  configuration payload to tiles
- busy  output  1  session in progress
- done  output  1  one-cycle pulse when a session completes
- records_written  output  16  records issued in the current or last session

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; config_addr=IDLE_ADDR; config_data=0; in_ready=0; busy=0; done=0; records_written=0.
  - Deassertion is synchronised internally; the first active edge is the second clk after reset rises.
- Byte transfer occurs when in_valid && in_ready at a rising clk edge.
- Session frame, all multi-byte fields MSB first:
  - 2-byte record count N.
  - Then N records of 8 bytes: 4 address bytes, then 4 data bytes.
- States:
  - IDLE: in_ready=0. start=1 -> CNT_HI, busy=1, records_written cleared to 0.
  - CNT_HI: in_ready=1. On transfer, latch N[15:8] -> CNT_LO.
  - CNT_LO: in_ready=1. On transfer, latch N[7:0]. If N==0 -> DONE, else -> LOAD with byte index 0.
  - LOAD: in_ready=1. Each transfer shifts the byte into a 64-bit assembly register and increments a 3-bit index. The 8th byte goes to WRITE. The bus remains at IDLE_ADDR while loading.
  - WRITE: in_ready=0.
    - config_addr/config_data driven from registers, valid the cycle after the 8th byte transfer.
    - Held exactly WRITE_CYCLES cycles. On the last cycle records_written increments.
    - If records_written+1 == N -> DONE, else -> LOAD.
    - The bus returns to IDLE_ADDR, config_data=0, on the cycle after the final write cycle.
  - DONE: done=1 for one cycle, busy=0 on the same cycle -> IDLE.
- Bus outputs are registered (glitch-free); no combinational path from in_* to config_*.
- Latency: last record byte accepted at edge k -> record on bus cycles k+1 .. k+WRITE_CYCLES.
- Idle or in_valid gaps mid-record: the loader waits indefinitely with index preserved; no timeout.
- start asserted while busy: ignored. start in the same cycle as done: ignored; a new start is required after IDLE.
- Record address whose upper half equals IDLE_ADDR upper half: still issued as written; no filtering.
- records_written saturates naturally; N≤65535 guarantees no overflow.
- Async reset mid-session: immediate abort, all outputs to reset values, partial record discarded, no write issued.

Test Plan:
1. Reset, then start. Stream 00 01, then 00 07 00 03 00 00 00 05 -> one cycle with config_addr=0x0007_0003, config_data=0x0000_0005. done pulses the cycle after; records_written=1; config_addr=0 otherwise.
2. N=3 records (cb0 tile 2 data 6; cb1 tile 2 data 1; compute_block tile 2 data 2), in_valid held high:
   - in_ready drops during each WRITE.
   - Exactly three single-cycle writes, in order, each separated by 8 LOAD cycles.
   - done after the third; records_written=3.
3. N=0 (bytes 00 00) -> done pulses 1 cycle after the second byte. No bus activity; records_written=0.
4. Random in_valid gaps (≈50% duty) across a 2-record session -> same bus values as scenario 2's first two records. No byte lost or duplicated; busy high throughout.
5. WRITE_CYCLES=3 instance, scenario 1 stream -> config_addr=0x0007_0003 held exactly 3 consecutive cycles, then IDLE_ADDR.
6. Assert reset after 5 bytes of record 1, then release; start again with a full 1-record stream -> no write from the aborted session. Outputs at reset values during reset; the second session completes normally with records_written=1.
